seg7_scan_display: RTL and testbench
====================================

# seg7_scan_display

Four-digit multiplexed seven-segment driver that consumes the 16-bit status word the CPU top level exposes and renders it as hex on the Basys board display. It latches a value on a load strobe and defers the update to a frame boundary so no scan shows mixed old and new digits. It time-multiplexes the four common anodes with a programmable refresh divider. It sits between the CPU status output and the board's seg/an pins, clocked from the board clock.

## Interface
- REFRESH_DIV, 100000: clock cycles each digit is lit (≥2); a frame is 4×REFRESH_DIV cycles.
- clk  in  1  board clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- data  in  16  value to display; nibble 0 → rightmost digit (an[0]).
- load  in  1  capture strobe; data sampled on any edge where load=1.
- blank_lz  in  1  1 = blank leading-zero digits.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit enables, active-low, exactly one low while scanning.
- frame  out  1  one-cycle pulse at each frame wrap.
- pending  out  1  1 = captured value not yet committed to display.

## Operation
- Registers: cnt (0..REFRESH_DIV-1), idx (2 bits), shadow[15:0], disp[15:0], pending, plus registered seg/an/frame.
- cnt increments each cycle; at cnt==REFRESH_DIV-1, cnt→0 and idx→idx+1 (3 wraps to 0).
- Wrap event: cnt==REFRESH_DIV-1 and idx==3. On it, frame=1 for that next cycle, and if pending: disp←shadow, pending←0.
- load=1 (no wrap): shadow←data, pending←1. Repeated loads before wrap: last one wins.
- load=1 coincident with wrap: disp←data directly, shadow←data, pending←0.
- Decode of disp nibble selected by idx: standard hex, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero blanking (blank_lz=1): digit k∈{1,2,3} is blanked (an bit held high, seg=1111111) when disp nibbles k..3 are all zero. Digit 0 is never blanked (value 0 shows "0"). blank_lz is sampled live and is not latched.
- an pattern for idx: 0→1110, 1→1101, 2→1011, 3→0111.

## Timing
- Reset (asserted): cnt=0, idx=0, shadow=disp=0, pending=0, frame=0, an=1111, seg=1111111.
- First rising edge after reset release: an=1110, seg=decode(disp[3:0])=1000000; digit 0 is lit for exactly REFRESH_DIV cycles from that edge.
- seg/an are registered: they change only on the edge after the counter terminal, simultaneously, with no intermediate glitch.
- Each digit is lit exactly REFRESH_DIV cycles; the frame period is exactly 4×REFRESH_DIV.
- New data becomes visible on digit 0 at the first edge after the wrap that commits it; worst-case latency from load is 4×REFRESH_DIV+1 cycles.
- pending rises the edge after load and falls on the commit edge.
- Reset mid-frame or mid-pending: everything clears asynchronously; the captured value is discarded.

## Test plan
- REFRESH_DIV=4, reset release, no load → an cycles 1110/1101/1011/0111, 4 cycles each, seg=1000000 throughout; frame pulses every 16 cycles.
- load data=16'h1A3F mid-frame → pending=1 until next wrap; next frame shows digits F(0001110), 3(0110000), A(0001000), 1(1111001) on an[0..3]; disp unchanged before the wrap.
- blank_lz=1, data=16'h0050 committed → an[3] and an[2] stay high during their slots; digit1 shows 5, digit0 shows 0. data=16'h0000 → only digit 0 lit, showing "0".
- Two loads (16'h1111 then 16'h2222) in the same frame → only 2222 is ever displayed. A load on the exact wrap cycle (16'hBEEF) → shown from the immediately following frame, pending stays 0.
- Assert reset while pending=1 with 16'hCAFE captured → an=1111 and seg=1111111 immediately (asynchronous); after release, 0000 is displayed and pending=0.
- REFRESH_DIV=2 boundary → each digit lit exactly 2 cycles, frame period 8, no skipped idx.

Source files
------------

// File: rtl/seg7_scan_display_if.sv
// Bundle between the CPU status word and the seven-segment scan driver.
interface seg7_scan_display_if;
  logic [15:0] data;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame;
  logic        pending;

  modport master (output data, load, blank_lz, input seg, an, frame, pending);
  modport slave  (input data, load, blank_lz, output seg, an, frame, pending);
endinterface

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed hex display driver; new values are committed only at a
// frame boundary so a scan never mixes old and new digits.
module seg7_scan_display #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  seg7_scan_display_if.slave   bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      shadow;
  logic [15:0]      disp;
  logic             pending_q;
  logic             frame_q;
  logic [6:0]       seg_q;
  logic [3:0]       an_q;

  logic             last_c;
  logic             wrap_c;
  logic [3:0]       nib_c;
  logic             lz_c;
  logic             blank_c;
  logic [3:0]       an_c;
  logic [6:0]       seg_c;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign last_c = (cnt == CNT_LAST);
  assign wrap_c = last_c && (idx == 2'd3);

  // Select the digit for the current slot and decide whether it is a leading zero.
  always_comb begin
    nib_c = disp[3:0];
    lz_c  = 1'b0;
    an_c  = 4'b1110;
    case (idx)
      2'd0: begin nib_c = disp[3:0];   lz_c = 1'b0;                an_c = 4'b1110; end
      2'd1: begin nib_c = disp[7:4];   lz_c = (disp[15:4]  == '0); an_c = 4'b1101; end
      2'd2: begin nib_c = disp[11:8];  lz_c = (disp[15:8]  == '0); an_c = 4'b1011; end
      default: begin nib_c = disp[15:12]; lz_c = (disp[15:12] == '0); an_c = 4'b0111; end
    endcase
    blank_c = bus.blank_lz && lz_c;
    seg_c   = hex7(nib_c);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      idx       <= 2'd0;
      shadow    <= 16'h0000;
      disp      <= 16'h0000;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
    end else begin
      cnt     <= last_c ? '0 : cnt + CNT_W'(1);
      if (last_c) idx <= idx + 2'd1;
      frame_q <= wrap_c;

      // A load on the wrap edge bypasses the shadow so it shows next frame.
      if (bus.load) begin
        shadow <= bus.data;
        if (wrap_c) begin
          disp      <= bus.data;
          pending_q <= 1'b0;
        end else begin
          pending_q <= 1'b1;
        end
      end else if (wrap_c && pending_q) begin
        disp      <= shadow;
        pending_q <= 1'b0;
      end

      an_q  <= blank_c ? 4'b1111 : an_c;
      seg_q <= blank_c ? 7'b1111111 : seg_c;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.an      = an_q;
  assign bus.frame   = frame_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: expected {frame,an,seg} per cycle are
// queued when stimulus is applied and popped as the display scans.
module tb_seg7_scan_display;

  logic clk;
  logic reset4;
  logic reset2;
  int   errors;
  int   checks;

  logic [11:0] sb[$];
  logic [6:0]  hex_tbl [16];

  seg7_scan_display_if b4();
  seg7_scan_display_if b2();

  seg7_scan_display #(.REFRESH_DIV(4)) u4 (.clk(clk), .reset(reset4), .bus(b4));
  seg7_scan_display #(.REFRESH_DIV(2)) u2 (.clk(clk), .reset(reset2), .bus(b2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue one full frame of expected outputs for the value being displayed.
  task automatic push_frame(input logic [15:0] val, input logic blz, input int r);
    logic [15:0] sh;
    logic        blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        fr;
    for (int k = 0; k < 4; k++) begin
      sh    = val >> (4 * k);
      blank = blz && (k > 0) && (sh == 16'h0000);
      an    = blank ? 4'b1111 : ~(4'b0001 << k);
      seg   = blank ? 7'b1111111 : hex_tbl[sh[3:0]];
      for (int j = 0; j < r; j++) begin
        fr = (k == 3) && (j == r - 1);
        sb.push_back({fr, an, seg});
      end
    end
  endtask

  task automatic drain(input int n, input bit sel2, input string tag);
    logic [11:0] obs;
    logic [11:0] exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs = sel2 ? {b2.frame, b2.an, b2.seg} : {b4.frame, b4.an, b4.seg};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s scoreboard empty observed=%h", tag, obs);
      end else begin
        exp = sb.pop_front();
        chk(tag, 32'(obs), 32'(exp));
      end
    end
  endtask

  initial begin
    hex_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    errors = 0;
    checks = 0;
    clk    = 1'b0;
    reset4 = 1'b0;
    reset2 = 1'b0;
    b4.data = 16'h0000; b4.load = 1'b0; b4.blank_lz = 1'b0;
    b2.data = 16'h0000; b2.load = 1'b0; b2.blank_lz = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_an", 32'(b4.an), 32'h0000000F);
    chk("rst_seg", 32'(b4.seg), 32'h0000007F);
    chk("rst_frame", 32'(b4.frame), 32'h0);
    chk("rst_pending", 32'(b4.pending), 32'h0);

    // Idle frame after release: 0000, frame pulse on the 16th cycle
    reset4 = 1'b1;
    push_frame(16'h0000, 1'b0, 4);
    drain(16, 1'b0, "idle_frame");

    // Load mid-frame; old value stays up until the wrap commits it
    b4.load = 1'b1; b4.data = 16'h1A3F;
    push_frame(16'h0000, 1'b0, 4);
    drain(1, 1'b0, "pre_commit");
    b4.load = 1'b0;
    chk("pending_set", 32'(b4.pending), 32'h1);
    drain(14, 1'b0, "pre_commit");
    chk("pending_hold", 32'(b4.pending), 32'h1);
    drain(1, 1'b0, "pre_commit");
    chk("pending_clear", 32'(b4.pending), 32'h0);
    b4.blank_lz = 1'b1;
    push_frame(16'h1A3F, 1'b1, 4);
    drain(1, 1'b0, "show_1a3f");

    // Leading-zero blanking of 0050, then 0000
    b4.load = 1'b1; b4.data = 16'h0050;
    drain(1, 1'b0, "show_1a3f");
    b4.load = 1'b0;
    drain(14, 1'b0, "show_1a3f");
    push_frame(16'h0050, 1'b1, 4);
    drain(1, 1'b0, "blank_0050");
    b4.load = 1'b1; b4.data = 16'h0000;
    drain(1, 1'b0, "blank_0050");
    b4.load = 1'b0;
    drain(14, 1'b0, "blank_0050");
    push_frame(16'h0000, 1'b1, 4);
    drain(16, 1'b0, "blank_0000");

    // Two loads in one frame: only the last is ever shown
    b4.blank_lz = 1'b0;
    b4.load = 1'b1; b4.data = 16'h1111;
    push_frame(16'h0000, 1'b0, 4);
    drain(1, 1'b0, "double_load");
    b4.data = 16'h2222;
    drain(1, 1'b0, "double_load");
    b4.load = 1'b0;
    drain(14, 1'b0, "double_load");
    push_frame(16'h2222, 1'b0, 4);
    drain(16, 1'b0, "show_2222");

    // Load exactly on the wrap edge goes straight to the display
    push_frame(16'h2222, 1'b0, 4);
    drain(15, 1'b0, "show_2222");
    b4.load = 1'b1; b4.data = 16'hBEEF;
    drain(1, 1'b0, "show_2222");
    b4.load = 1'b0;
    chk("wrap_load_pending", 32'(b4.pending), 32'h0);
    push_frame(16'hBEEF, 1'b0, 4);
    drain(16, 1'b0, "show_beef");

    // Asynchronous reset while CAFE is pending
    b4.load = 1'b1; b4.data = 16'hCAFE;
    push_frame(16'hBEEF, 1'b0, 4);
    drain(1, 1'b0, "pre_reset");
    b4.load = 1'b0;
    drain(4, 1'b0, "pre_reset");
    chk("cafe_pending", 32'(b4.pending), 32'h1);
    #2 reset4 = 1'b0;
    #1;
    chk("async_an", 32'(b4.an), 32'h0000000F);
    chk("async_seg", 32'(b4.seg), 32'h0000007F);
    chk("async_pending", 32'(b4.pending), 32'h0);
    chk("async_frame", 32'(b4.frame), 32'h0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset4 = 1'b1;
    push_frame(16'h0000, 1'b0, 4);
    drain(16, 1'b0, "post_reset");
    chk("post_reset_pending", 32'(b4.pending), 32'h0);

    // REFRESH_DIV=2: two cycles per digit, eight-cycle frame
    reset2 = 1'b1;
    b2.load = 1'b1; b2.data = 16'h4321;
    push_frame(16'h0000, 1'b0, 2);
    drain(1, 1'b0 | 1'b1, "div2_first");
    b2.load = 1'b0;
    chk("div2_pending", 32'(b2.pending), 32'h1);
    drain(7, 1'b1, "div2_first");
    chk("div2_commit", 32'(b2.pending), 32'h0);
    push_frame(16'h4321, 1'b0, 2);
    push_frame(16'h4321, 1'b0, 2);
    drain(16, 1'b1, "div2_4321");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
